// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if: byte-serial RAM bus plus UART TX stream between controller and responder
// Signals:
//   rdy       global ready; low freezes the responder
//   wr_en     0 read, 1 write
//   addr      byte address
//   din       write data
//   dout      read data, one cycle after addr
//   uart_full TX FIFO back-pressure
//   tx_valid  TX FIFO head byte available
//   tx_data   TX FIFO head byte
//   tx_ready  external UART accepts head byte
//   halt      sticky halt flag
//   overflow  sticky TX drop flag
interface ram_io_responder_if;
    logic        rdy;
    logic        wr_en;
    logic [31:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        uart_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic        overflow;
    modport master (
        output rdy, wr_en, addr, din, tx_ready,
        input  dout, uart_full, tx_valid, tx_data, halt, overflow
    );
    modport slave (
        input  rdy, wr_en, addr, din, tx_ready,
        output dout, uart_full, tx_valid, tx_data, halt, overflow
    );
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM with registered reads plus memory-mapped UART TX FIFO and halt register
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  ram_io_responder_if.slave (controller access, status outputs, UART TX stream)
// IO window: addr[17:16] == 2'b11; offset 0 = TX FIFO / RX (reads 0), offset 4 = halt / status.
module ram_io_responder #(
    parameter int ADDR_BITS  = 17,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = "test.data"
) (
    input logic clk,
    input logic rst,
    ram_io_responder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] ALMOST = (PW + 1)'(FIFO_DEPTH - 1);
    logic [7:0] ram [2**ADDR_BITS];
    logic [7:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0] count_q, count_d;
    logic [7:0] dout_q, dout_d;
    logic uart_full_q, halt_q, halt_d, overflow_q, overflow_d;
    logic io, full, tx_valid, pop, push_req, push, ram_we;
    logic [ADDR_BITS-1:0] idx;
    logic unused_addr;
    // Address bits above the IO decode are don't-care.
    assign unused_addr = ^bus.addr[31:18];
    always_comb begin
        io         = bus.addr[17:16] == 2'b11;
        idx        = bus.addr[ADDR_BITS-1:0];
        full       = count_q == DEPTH;
        tx_valid   = |count_q;
        pop        = bus.rdy && tx_valid && bus.tx_ready;
        push_req   = bus.rdy && bus.wr_en && io && bus.addr[2:0] == 3'd0;
        // A same-cycle pop frees a slot, so a push while full is still accepted.
        push       = push_req && (!full || pop);
        ram_we     = bus.rdy && bus.wr_en && !io;
        count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        halt_d     = halt_q || (bus.rdy && bus.wr_en && io && bus.addr[2:0] == 3'd4);
        overflow_d = overflow_q || (push_req && !push);
        dout_d     = !(bus.rdy && !bus.wr_en) ? dout_q :
                     !io ? ram[idx] :
                     bus.addr[2:0] == 3'd4 ? {6'b0, overflow_q, full} : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            uart_full_q <= 1'b0;
            halt_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            // One entry early: the controller sees this flag a cycle late.
            uart_full_q <= count_d >= ALMOST;
            halt_q      <= halt_d;
            overflow_q  <= overflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= bus.din;
    end
    always_ff @(posedge clk) begin
        if (push && !rst) fifo[wr_ptr_q] <= bus.din;
    end
    assign bus.dout      = dout_q;
    assign bus.uart_full = uart_full_q;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_valid ? fifo[rd_ptr_q] : 8'h00;
    assign bus.halt      = halt_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: scoreboard bench for ram_io_responder (directed vectors, decoupled monitor)
module tb_ram_io_responder;
    localparam int K_DOUT = 0, K_UF = 1, K_HALT = 2, K_OVF = 3, K_TXV = 4, K_TXD = 5;
    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];
    logic [7:0] tx_q[$];
    logic [7:0] v2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ram_io_responder_if bus();
    ram_io_responder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [7:0] pick(input int k);
        case (k)
            K_DOUT:  return bus.dout;
            K_UF:    return {7'b0, bus.uart_full};
            K_HALT:  return {7'b0, bus.halt};
            K_OVF:   return {7'b0, bus.overflow};
            K_TXV:   return {7'b0, bus.tx_valid};
            default: return bus.tx_data;
        endcase
    endfunction
    function automatic string kname(input int k);
        case (k)
            K_DOUT:  return "dout";
            K_UF:    return "uart_full";
            K_HALT:  return "halt";
            K_OVF:   return "overflow";
            K_TXV:   return "tx_valid";
            default: return "tx_data";
        endcase
    endfunction
    // Scoreboard monitor: register checks due this cycle, and the TX stream on each handshake.
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = pick(sb[i].kind);
                compared++;
                if (act !== sb[i].val || sb[i].cyc != cyc) begin
                    mismatched++;
                    $display("FAIL %s cycle %0d: got %h expected %h", kname(sb[i].kind), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (!rst && bus.rdy && bus.tx_valid && bus.tx_ready) begin
            compared++;
            if (tx_q.size() == 0) begin
                mismatched++;
                $display("FAIL tx_stream cycle %0d: got %h expected no byte", cyc, bus.tx_data);
            end else begin
                if (bus.tx_data !== tx_q[0]) begin
                    mismatched++;
                    $display("FAIL tx_stream cycle %0d: got %h expected %h", cyc, bus.tx_data, tx_q[0]);
                end
                void'(tx_q.pop_front());
            end
        end
    end
    task automatic chk(input int k, input logic [7:0] v);
        sb.push_back('{cyc + 1, k, v});
    endtask
    task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d, input logic txr);
        bus.rdy = r;
        bus.wr_en = w;
        bus.addr = a;
        bus.din = d;
        bus.tx_ready = txr;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input logic txr);
        tick(1'b1, 1'b0, 32'h30000, 8'h00, txr);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end
    initial begin
        // Reset values
        rst = 1'b1;
        chk(K_DOUT, 8'h00); chk(K_UF, 8'h00); chk(K_TXV, 8'h00);
        chk(K_TXD, 8'h00); chk(K_HALT, 8'h00); chk(K_OVF, 8'h00);
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        // Write then read same address
        tick(1'b1, 1'b1, 32'h100, 8'hA5, 1'b0);
        chk(K_DOUT, 8'hA5);
        tick(1'b1, 1'b0, 32'h100, 8'h00, 1'b0);
        // Pipelined read stream, upper address bits ignored on the writes
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 32'hF000_0200 + 32'(i), v2[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk(K_DOUT, v2[i]);
            tick(1'b1, 1'b0, 32'h200 + 32'(i), 8'h00, 1'b0);
        end
        // Fill FIFO, early full flag, overflow on ninth push, status byte
        for (int i = 1; i <= 8; i++) begin
            chk(K_UF, (i >= 7) ? 8'h01 : 8'h00);
            chk(K_OVF, 8'h00);
            tick(1'b1, 1'b1, 32'h30000, 8'h41, 1'b0);
        end
        chk(K_OVF, 8'h01);
        tick(1'b1, 1'b1, 32'h30000, 8'h42, 1'b0);
        chk(K_DOUT, 8'h03);
        tick(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0);
        // Halt is sticky; reset mid-drain empties the FIFO and clears flags
        chk(K_HALT, 8'h01);
        tick(1'b1, 1'b1, 32'h30004, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'h41);
            chk(K_HALT, 8'h01);
            idle(1'b1);
        end
        rst = 1'b1;
        chk(K_TXV, 8'h00); chk(K_OVF, 8'h00); chk(K_HALT, 8'h00);
        chk(K_UF, 8'h00); chk(K_DOUT, 8'h00);
        idle(1'b1);
        rst = 1'b0;
        // Full FIFO: push and pop in the same cycle is not a drop
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(8'h10 + 8'(i));
            if (i == 7) chk(K_UF, 8'h01);
            tick(1'b1, 1'b1, 32'h30000, 8'h10 + 8'(i), 1'b0);
        end
        tx_q.push_back(8'h5A);
        chk(K_OVF, 8'h00);
        chk(K_UF, 8'h01);
        tick(1'b1, 1'b1, 32'h30000, 8'h5A, 1'b1);
        chk(K_DOUT, 8'h01);
        tick(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk(K_UF, 8'h01);
            if (i == 1) chk(K_UF, 8'h00);
            if (i == 7) chk(K_TXV, 8'h00);
            idle(1'b1);
        end
        // rdy low freezes dout and the FIFO during a read stream
        tx_q.push_back(8'h61);
        tick(1'b1, 1'b1, 32'h30000, 8'h61, 1'b0);
        tx_q.push_back(8'h62);
        tick(1'b1, 1'b1, 32'h30000, 8'h62, 1'b0);
        chk(K_DOUT, 8'h11);
        tick(1'b1, 1'b0, 32'h200, 8'h00, 1'b0);
        chk(K_DOUT, 8'h22);
        tick(1'b1, 1'b0, 32'h201, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk(K_DOUT, 8'h22);
            chk(K_TXV, 8'h01);
            chk(K_TXD, 8'h61);
            tick(1'b0, 1'b0, 32'h202, 8'h00, 1'b1);
        end
        chk(K_DOUT, 8'h33);
        tick(1'b1, 1'b0, 32'h202, 8'h00, 1'b1);
        chk(K_DOUT, 8'h44);
        tick(1'b1, 1'b0, 32'h203, 8'h00, 1'b1);
        chk(K_TXV, 8'h00);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        compared++;
        if (tx_q.size() != 0) begin
            mismatched++;
            $display("FAIL tx_drain: got %0d bytes outstanding expected 0", tx_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
